// File: rtl/cpc_ram_paging_ctrl_pkg.sv
// Shared definitions for the CPC external RAM paging controller:
// map modes, port data tag, write-filter states and the block decoder.
package cpc_ram_pkg;

    localparam logic [2:0] MODE_0 = 3'd0;
    localparam logic [2:0] MODE_1 = 3'd1;
    localparam logic [2:0] MODE_2 = 3'd2;
    localparam logic [2:0] MODE_3 = 3'd3;
    localparam logic [2:0] MODE_4 = 3'd4;
    localparam logic [2:0] MODE_5 = 3'd5;
    localparam logic [2:0] MODE_6 = 3'd6;
    localparam logic [2:0] MODE_7 = 3'd7;

    // D7:D6 value that marks a write to the gate-array port as a RAM paging command
    localparam logic [1:0] PORT_DATA_TAG = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_ARMED  = 2'd1,
        WR_REJECT = 2'd2
    } wr_state_e;

    // Returns {hit, blk[1:0]} for a map mode and Z80 region r = A[15:14]
    function automatic logic [2:0] blk_decode(input logic [2:0] mode, input logic [1:0] r);
        logic [2:0] res;
        res = 3'b000;
        case (mode)
            MODE_0: res = 3'b000;
            MODE_1, MODE_3: if (r == 2'd3) res = {1'b1, 2'd3};
            MODE_2: res = {1'b1, r};
            MODE_4, MODE_5, MODE_6, MODE_7: if (r == 2'd1) res = {1'b1, mode[1:0]};
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cpc_ram_paging_ctrl_if.sv
// Z80 bus, SRAM control and committed page state of the paging controller.
interface cpc_ram_paging_ctrl_if #(parameter int BANK_BITS = 3);

    logic [15:0]          A;
    logic [7:0]           D;
    logic                 MREQ_B;
    logic                 IOREQ_B;
    logic                 WR_B;
    logic                 RAMRD_B;
    logic [BANK_BITS+1:0] ram_adr_hi;
    logic                 ramcs_b;
    logic                 ramwe_b;
    logic                 ramoe_b;
    logic                 RAMDIS;
    logic [2:0]           page_mode;
    logic [BANK_BITS-1:0] page_bank;

    modport master (
        output A, D, MREQ_B, IOREQ_B, WR_B, RAMRD_B,
        input  ram_adr_hi, ramcs_b, ramwe_b, ramoe_b, RAMDIS, page_mode, page_bank
    );

    modport slave (
        input  A, D, MREQ_B, IOREQ_B, WR_B, RAMRD_B,
        output ram_adr_hi, ramcs_b, ramwe_b, ramoe_b, RAMDIS, page_mode, page_bank
    );

endinterface

// File: rtl/cpc_page_wr_filter.sv
// Clocked glitch filter for paging OUTs: counts qualified samples, keeps the
// last sampled value in a shadow and pulses commit when the strobe releases.
module cpc_page_wr_filter #(
    parameter int BANK_BITS  = 3,
    parameter int MIN_WR_CYC = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_B,
    input  logic                 qual,
    input  logic [BANK_BITS-1:0] load_bank,
    input  logic [2:0]           load_mode,
    output logic                 commit,
    output logic [BANK_BITS-1:0] shadow_bank,
    output logic [2:0]           shadow_mode
);
    import cpc_ram_pkg::*;

    localparam logic [2:0] MIN_CNT = 3'(MIN_WR_CYC);

    wr_state_e            state_reg, state_next;
    logic [2:0]           cnt_reg, cnt_next;
    logic [BANK_BITS-1:0] bank_reg;
    logic [2:0]           mode_reg;
    logic                 load;

    always_ff @(posedge CLK) begin
        if (!RESET_B) begin
            state_reg <= WR_IDLE;
            cnt_reg   <= 3'd0;
            bank_reg  <= '0;
            mode_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (load) begin
                bank_reg <= load_bank;
                mode_reg <= load_mode;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            WR_IDLE: begin
                if (qual) begin
                    state_next = WR_ARMED;
                    cnt_next   = 3'd1;
                    load       = 1'b1;
                end
            end
            WR_ARMED: begin
                if (qual) begin
                    // Saturate so long strobes never wrap below the threshold
                    if (cnt_reg != 3'd7) cnt_next = cnt_reg + 3'd1;
                    load = 1'b1;
                end else begin
                    cnt_next = 3'd0;
                    if (cnt_reg >= MIN_CNT) begin
                        commit     = 1'b1;
                        state_next = WR_IDLE;
                    end else begin
                        state_next = WR_REJECT;
                    end
                end
            end
            WR_REJECT: state_next = WR_IDLE;
            default:   state_next = WR_IDLE;
        endcase
    end

    assign shadow_bank = bank_reg;
    assign shadow_mode = mode_reg;

endmodule

// File: rtl/cpc_ram_paging_ctrl.sv
// CPC external RAM paging controller: committed bank/mode registers plus the
// combinational SRAM decode from live Z80 bus signals.
module cpc_ram_paging_ctrl #(
    parameter int BANK_BITS  = 3,
    parameter int MIN_WR_CYC = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_B,
    cpc_ram_paging_ctrl_if.slave bus
);
    import cpc_ram_pkg::*;

    logic                 qual;
    logic [BANK_BITS-1:0] port_bank;
    logic                 commit;
    logic [BANK_BITS-1:0] shadow_bank;
    logic [2:0]           shadow_mode;
    logic [2:0]           page_mode_reg;
    logic [BANK_BITS-1:0] page_bank_reg;
    logic [2:0]           dec;
    logic                 sel;
    logic                 cs_b;
    logic                 unused_bus;

    assign qual = !bus.IOREQ_B && !bus.WR_B && !bus.A[15] && (bus.D[7:6] == PORT_DATA_TAG);

    // Low three bank bits come from D5:D3, wider banks take the rest from the port address
    for (genvar gi = 0; gi < BANK_BITS; gi++) begin : g_bank_bit
        if (gi < 3) begin : g_data
            assign port_bank[gi] = bus.D[3+gi];
        end else begin : g_addr
            assign port_bank[gi] = bus.A[gi];
        end
    end

    cpc_page_wr_filter #(
        .BANK_BITS  (BANK_BITS),
        .MIN_WR_CYC (MIN_WR_CYC)
    ) u_wr_filter (
        .CLK         (CLK),
        .RESET_B     (RESET_B),
        .qual        (qual),
        .load_bank   (port_bank),
        .load_mode   (bus.D[2:0]),
        .commit      (commit),
        .shadow_bank (shadow_bank),
        .shadow_mode (shadow_mode)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_B) begin
            page_mode_reg <= MODE_0;
            page_bank_reg <= '0;
        end else if (commit) begin
            page_mode_reg <= shadow_mode;
            page_bank_reg <= shadow_bank;
        end
    end

    always_comb begin
        dec  = blk_decode(page_mode_reg, bus.A[15:14]);
        sel  = dec[2];
        cs_b = !(sel && !bus.MREQ_B);
    end

    assign bus.RAMDIS     = sel;
    assign bus.ramcs_b    = cs_b;
    assign bus.ramwe_b    = bus.WR_B | bus.MREQ_B;
    assign bus.ramoe_b    = bus.RAMRD_B | cs_b;
    assign bus.ram_adr_hi = {page_bank_reg, (sel ? dec[1:0] : 2'b00)};
    assign bus.page_mode  = page_mode_reg;
    assign bus.page_bank  = page_bank_reg;

    // Address/data bits outside the decoded fields are intentionally ignored
    assign unused_bus = ^{bus.A, bus.D};

endmodule
